// File: rtl/ram_window_reader.sv
// Read-side controller for the sliding-window RAM buffer: walks the cursor, keeps a
// running WIN-byte sum and streams results over valid/ready. `WIN_AVG_EN selects mean output.
module ram_window_reader #(
  parameter int DEPTH = 64,
  parameter int WIN   = 4,
  parameter int DW    = 8,
  parameter int SW    = DW + $clog2(WIN)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Full,
  input  logic          Empty,
  input  logic [DW-1:0] Dout,
  output logic          Start,
  output logic          Sliding,
  output logic          Win_valid,
  input  logic          Win_ready,
  output logic [SW-1:0] Win_data,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(WIN);
  localparam logic [CW-1:0] WIN_C   = CW'(WIN);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, ARM, FETCH, CAP, EMIT, SLIDE, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] win_q [WIN];
  logic [DW-1:0] win_d [WIN];
  logic [DW-1:0] oldest;
  logic [SW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          start_q, busy_q, sliding_q, valid_q, done_q;
  logic          abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    win_d   = win_q;
    data_d  = data_q;
    err_d   = err_q;
    oldest  = '0;
    abort   = (state_q inside {FETCH, CAP, EMIT, SLIDE}) && Empty && (cnt_q != DEPTH_C);

    case (state_q)
      IDLE: if (Full) state_d = ARM;
      ARM: begin
        cnt_d = '0;
        sum_d = '0;
        for (int unsigned i = 0; i < WIN; i++) win_d[i] = '0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: state_d = CAP;
      CAP: begin
        // Oldest byte is read before the shift; zero until the window has filled.
        oldest   = (cnt_q < WIN_C) ? '0 : win_q[WIN-1];
        sum_d    = sum_q + SW'(Dout) - SW'(oldest);
        win_d[0] = Dout;
        for (int unsigned i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
        cnt_d = cnt_q + 1'b1;
`ifdef WIN_AVG_EN
        data_d = sum_d >> LW;
`else
        data_d = sum_d;
`endif
        if (cnt_d >= WIN_C)        state_d = EMIT;
        else if (cnt_d == DEPTH_C) state_d = DONE;
        else                       state_d = SLIDE;
      end
      EMIT: if (Win_ready) state_d = (cnt_q == DEPTH_C) ? DONE : SLIDE;
      SLIDE: state_d = FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      sliding_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      win_q     <= win_d;
      data_q    <= data_d;
      err_q     <= err_d;
      start_q   <= (state_d != IDLE);
      busy_q    <= (state_d != IDLE);
      sliding_q <= (state_d == SLIDE);
      valid_q   <= (state_d == EMIT);
      done_q    <= (state_d == DONE);
    end
  end

  assign Start     = start_q;
  assign Busy      = busy_q;
  assign Sliding   = sliding_q;
  assign Win_valid = valid_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign Win_data  = data_q;

endmodule

// File: doc/ram_window_reader.md
# ram_window_reader

Read-side controller for the sliding-window RAM buffer (`RAM_TOP`), driving its `Start` and `Sliding` inputs.
- Waits until the buffer reports `Full`, then walks the cursor from 0 to DEPTH-1, one byte per `Sliding` pulse.
- Keeps a running sum over the last WIN bytes read from `Dout`.
- Streams each window result downstream over a valid/ready handshake.
- Sits between the RAM buffer and the processing stage that consumes windowed data.

## Interface
Parameters:
- DEPTH, 64: bytes per buffer session; must match the buffer depth (cursor range 0..DEPTH-1).
- WIN, 4: window length; power of two, 2..16.
- DW, 8: data width of `Dout`.
- SW, DW+$clog2(WIN): result width, fixed by formula, not overridden.

Ports (one clock; reset is synchronous and active-low):
- Clk  in  1  system clock, 50 MHz, all logic on rising edge.
- Rst  in  1  synchronous reset, active-low: `Rst`=0 at a rising edge resets the block.
- Full  in  1  buffer holds DEPTH valid bytes.
- Empty  in  1  buffer has no valid data.
- Dout  in  DW  buffer byte at current cursor, valid one cycle after the cursor changes.
- Start  out  1  level, high for the whole read session.
- Sliding  out  1  one-cycle pulse; advances the buffer cursor by 1.
- Win_valid  out  1  `Win_data` holds a result.
- Win_ready  in  1  downstream accepts the result.
- Win_data  out  SW  window result.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at the end of a session.
- Err  out  1  sticky flag: session ended early on `Empty`. Cleared on the next ARM.

## Operation
FSM states: IDLE, ARM, FETCH, CAP, EMIT, SLIDE, DONE.
- **IDLE**
  - `Start`=0.
  - Goes to ARM when `Full`=1.
- **ARM**
  - `Start`=1 from this state through DONE.
  - Clears byte count `cnt`, the window shift register and `sum`.
  - Clears `Err`.
  - Goes to FETCH.
- **FETCH**
  - One wait cycle for the RAM read latency.
  - Goes to CAP.
- **CAP**
  - Samples `Dout`, shifts it into a WIN-deep register, and sets `sum` = `sum` + `Dout` - oldest byte (oldest byte is 0 while `cnt`<WIN).
  - Increments `cnt`.
  - If `cnt` (after increment) ≥ WIN, goes to EMIT.
  - Otherwise, if `cnt`==DEPTH, goes to DONE.
  - Otherwise goes to SLIDE.
- **EMIT**
  - `Win_valid`=1 with `Win_data` held stable.
  - Leaves on the cycle where `Win_valid`=1 and `Win_ready`=1: to DONE if `cnt`==DEPTH, else to SLIDE.
- **SLIDE**
  - `Sliding`=1 for exactly one cycle.
  - Goes to FETCH.
- **DONE**
  - `Done`=1 for one cycle; `Start`=0 from the next cycle on.
  - Goes to IDLE.

Arithmetic:
- `sum` is SW bits wide, unsigned, and cannot overflow.
- The oldest byte is taken from the shift register before the shift.

Boundary conditions:
- `Empty`=1 in FETCH/CAP/EMIT/SLIDE before `cnt`==DEPTH: set `Err`=1, discard any pending result (`Win_valid` drops), go to DONE.
- `Full` deasserting mid-session is ignored.
- `Sliding` is never issued while `Win_valid`=1, so a stalled consumer stalls the cursor.
- `Win_ready`=1 while `Win_valid`=0 is ignored.
- Reset mid-session: next state is IDLE; every output returns to its reset value; `cnt`, `sum` and the window are cleared.

## Timing
- Reset values: `Start`=0, `Sliding`=0, `Win_valid`=0, `Win_data`=0, `Busy`=0, `Done`=0, `Err`=0.
- All outputs are registered (no combinational input-to-output path).
- `Full` sampled high in IDLE gives `Start`=1 on the next cycle.
- Minimum per-byte cost is 3 cycles (SLIDE, FETCH, CAP) plus at least 1 EMIT cycle once the window is full.
- With `Win_ready` tied high, the session for DEPTH=64, WIN=4 ends 1+64·2+63+61 cycles after ARM (FETCH/CAP per byte, SLIDE between bytes, EMIT per result).
- Cursor/Dout assumption: the cursor updates on the edge ending SLIDE, and `Dout` is valid at the edge ending CAP.

## Configuration
- `WIN_AVG_EN` defined:
  - `Win_data` = `sum` >> $clog2(WIN), the truncated mean.
  - Zero-extended to SW bits.
- `WIN_AVG_EN` undefined:
  - `Win_data` = `sum`, the full-width window sum.
- FSM, handshake and port list are identical in both builds.

## Test plan
- Buffer loaded with bytes 1..64, `Full`=1, `Win_ready`=1, macro off:
  - 61 results, first 10 (1+2+3+4), last 250 (61+62+63+64).
  - 63 `Sliding` pulses, one `Done`, `Err`=0.
- Same stimulus with `WIN_AVG_EN`:
  - Results 2, 3, 4, … 62 (sum>>2).
- `Win_ready` held low 10 cycles on the first result:
  - `Win_valid`=1 and `Win_data`=10 stable throughout.
  - No `Sliding` pulse during the stall.
  - Flow resumes one cycle after `Win_ready`=1.
- Force `Empty`=1 after 20 bytes:
  - 17 results emitted, then `Done` pulse.
  - `Err`=1 until the next ARM; `Start`=0.
- `Rst`=0 for one edge during EMIT of the 5th result:
  - All outputs read 0 the next cycle, FSM in IDLE.
  - The next `Full` starts a fresh session whose first result is again 10.
- All bytes 255, WIN=16, macro off:
  - Every result 4080 (fits SW=12 bits), no wrap.
